// File: rtl/my_spi_pkg.sv
// Shared constants for the my_spi SPI mode-0 slave.
//   SPI_WIDTH        default frame width in bits
//   SPI_SYNC_STAGES  default depth of the pin synchronizers
//   MISO_IDLE        level driven on MISO while deselected
//   NO_DATA          reply byte sent when no tx data is offered
package my_spi_pkg;

    localparam int unsigned SPI_WIDTH       = 8;
    localparam int unsigned SPI_SYNC_STAGES = 2;

    localparam logic       MISO_IDLE = 1'b0;
    localparam logic [7:0] NO_DATA   = 8'h00;

endpackage : my_spi_pkg

// File: rtl/my_spi_if.sv
// Bus bundle for my_spi: SPI pins, receive/transmit byte handshake and debug probe.
//   slave  : the my_spi block (samples SPI pins and tx side, drives MISO and rx side)
//   master : the surrounding system / SPI master model
interface my_spi_if
    import my_spi_pkg::*;
#(
    parameter int unsigned WIDTH = SPI_WIDTH
);

    logic             iSPIClk;
    logic             iSPIMOSI;
    logic             iSPICS;
    logic             oSPIMISO;
    logic [WIDTH-1:0] oRx;
    logic             oRxReady;
    logic [WIDTH-1:0] tx;
    logic             txReady;
    logic [15:0]      probe;

    modport slave (
        input  iSPIClk, iSPIMOSI, iSPICS, tx, txReady, probe,
        output oSPIMISO, oRx, oRxReady
    );

    modport master (
        output iSPIClk, iSPIMOSI, iSPICS, tx, txReady, probe,
        input  oSPIMISO, oRx, oRxReady
    );

endinterface : my_spi_if

// File: rtl/my_spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input with edge pulses.
//   clk, rst_n : sysclk domain clock and async active-low reset
//   async_in   : raw pin
//   sync       : synchronized level (reset value RESET_VAL)
//   rise_c     : one-cycle pulse on a synchronized 0->1 transition
//   fall_c     : one-cycle pulse on a synchronized 1->0 transition
module spi_sync_edge #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync,
    output logic rise_c,
    output logic fall_c
);

    logic [STAGES-1:0] chain;
    logic              prev;

    // Synchronizer chain plus one delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], async_in};
            prev  <= chain[STAGES-1];
        end
    end

    assign sync   = chain[STAGES-1];
    assign rise_c = sync & ~prev;
    assign fall_c = ~sync & prev;

endmodule : spi_sync_edge

// File: rtl/my_spi.sv
// SPI mode-0 slave (CPOL=0, CPHA=0, MSB first) oversampled by sysclk.
//   sysclk : system clock, all logic on rising edge
//   iRstN  : async active-low reset, release synchronized internally
//   bus    : my_spi_if slave modport (SPI pins, oRx/oRxReady, tx/txReady, probe)
module my_spi
    import my_spi_pkg::*;
#(
    parameter int unsigned WIDTH       = SPI_WIDTH,
    parameter int unsigned SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic     sysclk,
    input  logic     iRstN,
    my_spi_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [1:0]             rst_chain;
    logic                   rst_n;
    logic                   sck_sync;
    logic                   sck_rise;
    logic                   sck_fall;
    logic                   cs_sync;
    logic                   cs_fall;
    logic                   cs_rise_unused;
    logic                   sck_level_unused;
    logic [SYNC_STAGES-1:0] mosi_chain;
    logic                   mosi;
    logic [CNT_W-1:0]       bit_cnt;
    logic [WIDTH-2:0]       rx_sh;
    logic [WIDTH-1:0]       tx_sh;
    logic [WIDTH-1:0]       rx_q;
    logic                   rx_ready_q;
    logic [WIDTH-1:0]       load_val_c;
    logic                   probe_unused;

    // Reset asserts asynchronously, releases on a sysclk edge.
    always_ff @(posedge sysclk or negedge iRstN) begin
        if (!iRstN) begin
            rst_chain <= 2'b00;
        end else begin
            rst_chain <= {rst_chain[0], 1'b1};
        end
    end
    assign rst_n = rst_chain[1];

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
        .clk      (sysclk),
        .rst_n    (rst_n),
        .async_in (bus.iSPIClk),
        .sync     (sck_sync),
        .rise_c   (sck_rise),
        .fall_c   (sck_fall)
    );

    // CS resets to deselected so reset release never fakes a falling edge.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk      (sysclk),
        .rst_n    (rst_n),
        .async_in (bus.iSPICS),
        .sync     (cs_sync),
        .rise_c   (cs_rise_unused),
        .fall_c   (cs_fall)
    );

    assign sck_level_unused = sck_sync;

    // MOSI uses the same depth as SCK so data and clock stay aligned.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_chain <= '0;
        end else begin
            mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], bus.iSPIMOSI};
        end
    end
    assign mosi = mosi_chain[SYNC_STAGES-1];

    assign load_val_c = bus.txReady ? bus.tx : WIDTH'(NO_DATA);

    // Shift engine. The byte-boundary tx load is taken on the first falling
    // SCK of the new byte (bit_cnt wrapped to 0), which gives the host the
    // rest of the last SCK high phase to react to oRxReady before the reply
    // is captured. MISO is the registered MSB of the transmit shifter.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            rx_sh      <= '0;
            tx_sh      <= '0;
            rx_q       <= '0;
            rx_ready_q <= 1'b0;
        end else begin
            rx_ready_q <= 1'b0;
            if (cs_fall) begin
                // CS wins over any SCK edge detected in the same cycle.
                bit_cnt <= '0;
                rx_sh   <= '0;
                tx_sh   <= load_val_c;
            end else if (cs_sync) begin
                // Deselected: drop any partial byte and idle MISO.
                bit_cnt <= '0;
                rx_sh   <= '0;
                tx_sh   <= {WIDTH{MISO_IDLE}};
            end else begin
                if (sck_rise) begin
                    rx_sh   <= {rx_sh[WIDTH-3:0], mosi};
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                        rx_q       <= {rx_sh, mosi};
                        rx_ready_q <= 1'b1;
                    end
                end
                if (sck_fall) begin
                    if (bit_cnt == '0) begin
                        tx_sh <= load_val_c;
                    end else begin
                        tx_sh <= {tx_sh[WIDTH-2:0], 1'b0};
                    end
                end
            end
        end
    end

    assign bus.oSPIMISO = tx_sh[WIDTH-1];
    assign bus.oRx      = rx_q;
    assign bus.oRxReady = rx_ready_q;

    // Debug bus is observed only.
    assign probe_unused = ^bus.probe;

endmodule : my_spi

// File: tb/tb_my_spi.sv
// Self-checking bench for my_spi: SPI master model at sysclk/8, pulse monitor,
// and a byte-level reference model of received bytes and MISO replies.
module tb_my_spi;

    logic sysclk;
    logic iRstN;

    my_spi_if #(.WIDTH(8)) bus ();

    my_spi #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .sysclk (sysclk),
        .iRstN  (iRstN),
        .bus    (bus.slave)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    int n_cmp;
    int n_bad;
    int cyc;
    int pulse_cyc;
    int rise_cyc;
    int long_pulses;
    logic prev_ready;
    logic [7:0] rx_q[$];

    always @(posedge sysclk) cyc++;

    // Record every oRxReady pulse and flag any pulse longer than one cycle.
    always @(negedge sysclk) begin
        if (bus.oRxReady === 1'b1) begin
            rx_q.push_back(bus.oRx);
            pulse_cyc = cyc;
            if (prev_ready === 1'b1) long_pulses++;
        end
        prev_ready = bus.oRxReady;
    end

    // Master drives nbits of mo MSB-first; MISO captured just before each rising SCK.
    task automatic spi_bits(input logic [7:0] mo, input int nbits, input bit upd,
                            input logic [7:0] ntx, input bit nrdy, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            @(negedge sysclk);
            bus.iSPIMOSI = mo[i];
            repeat (3) @(negedge sysclk);
            mi[i] = bus.oSPIMISO;
            bus.iSPIClk = 1'b1;
            rise_cyc = cyc;
            if (upd && i == 4) begin
                bus.tx      = ntx;
                bus.txReady = nrdy;
            end
            repeat (4) @(negedge sysclk);
            bus.iSPIClk = 1'b0;
        end
    endtask

    task automatic cs_low();
        @(negedge sysclk);
        bus.iSPICS = 1'b0;
        repeat (6) @(negedge sysclk);
    endtask

    task automatic cs_high();
        repeat (4) @(negedge sysclk);
        bus.iSPICS = 1'b1;
        repeat (6) @(negedge sysclk);
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (bus.oRx !== 8'h00 || bus.oRxReady !== 1'b0 || bus.oSPIMISO !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hold: rx=%h rdy=%b miso=%b, want 00/0/0", bus.oRx, bus.oRxReady, bus.oSPIMISO);
        end
        repeat (3) @(negedge sysclk);
        iRstN = 1'b1;
        repeat (6) @(negedge sysclk);
        n_cmp++;
        if (bus.oRx !== 8'h00 || bus.oSPIMISO !== 1'b0 || rx_q.size() != 0) begin
            n_bad++;
            $display("FAIL reset_release: rx=%h miso=%b pulses=%0d, want 00/0/0", bus.oRx, bus.oSPIMISO, rx_q.size());
        end
    endtask

    task automatic test_basic();
        logic [7:0] mi;
        rx_q.delete();
        long_pulses = 0;
        cs_low();
        spi_bits(8'hA5, 8, 1'b0, 8'h00, 1'b0, mi);
        n_cmp++;
        if (pulse_cyc - rise_cyc < 1 || pulse_cyc - rise_cyc > 4) begin
            n_bad++;
            $display("FAIL basic_latency: %0d cycles, want 1..4", pulse_cyc - rise_cyc);
        end
        cs_high();
        n_cmp++;
        if (rx_q.size() != 1 || long_pulses != 0) begin
            n_bad++;
            $display("FAIL basic_pulses: count=%0d long=%0d, want 1/0", rx_q.size(), long_pulses);
        end else begin
            n_cmp++;
            if (rx_q[0] !== 8'hA5 || bus.oRx !== 8'hA5) begin
                n_bad++;
                $display("FAIL basic_rx: pulse=%h held=%h, want a5", rx_q[0], bus.oRx);
            end
        end
    endtask

    task automatic test_tx_reply();
        logic [7:0] mi;
        bus.tx = 8'h3C; bus.txReady = 1'b1;
        cs_low();
        spi_bits(8'h00, 8, 1'b0, 8'h00, 1'b0, mi);
        cs_high();
        n_cmp++;
        if (mi !== 8'h3C) begin
            n_bad++;
            $display("FAIL tx_ready: miso=%h, want 3c", mi);
        end
        n_cmp++;
        if (bus.oSPIMISO !== 1'b0) begin
            n_bad++;
            $display("FAIL miso_idle: miso=%b, want 0", bus.oSPIMISO);
        end
        bus.txReady = 1'b0;
        cs_low();
        spi_bits(8'h00, 8, 1'b0, 8'h00, 1'b0, mi);
        cs_high();
        n_cmp++;
        if (mi !== 8'h00) begin
            n_bad++;
            $display("FAIL tx_not_ready: miso=%h, want 00", mi);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] mi;
        rx_q.delete();
        cs_low();
        spi_bits(8'h01, 8, 1'b0, 8'h00, 1'b0, mi);
        spi_bits(8'hFF, 8, 1'b0, 8'h00, 1'b0, mi);
        cs_high();
        n_cmp++;
        if (rx_q.size() != 2) begin
            n_bad++;
            $display("FAIL b2b_count: pulses=%0d, want 2", rx_q.size());
        end else begin
            n_cmp++;
            if (rx_q[0] !== 8'h01 || rx_q[1] !== 8'hFF) begin
                n_bad++;
                $display("FAIL b2b_data: got %h %h, want 01 ff", rx_q[0], rx_q[1]);
            end
        end
    endtask

    task automatic test_abort();
        logic [7:0] mi;
        rx_q.delete();
        cs_low();
        spi_bits(8'hE7, 5, 1'b0, 8'h00, 1'b0, mi);
        cs_high();
        n_cmp++;
        if (rx_q.size() != 0 || bus.oRx !== 8'hFF) begin
            n_bad++;
            $display("FAIL abort_partial: pulses=%0d rx=%h, want 0 ff", rx_q.size(), bus.oRx);
        end
        cs_low();
        spi_bits(8'h5A, 8, 1'b0, 8'h00, 1'b0, mi);
        cs_high();
        n_cmp++;
        if (rx_q.size() != 1 || bus.oRx !== 8'h5A) begin
            n_bad++;
            $display("FAIL abort_next: pulses=%0d rx=%h, want 1 5a", rx_q.size(), bus.oRx);
        end
    endtask

    task automatic test_cs_high_ignore();
        logic [7:0] mi;
        rx_q.delete();
        bus.tx = 8'hFF; bus.txReady = 1'b1;
        spi_bits(8'h81, 8, 1'b0, 8'h00, 1'b0, mi);
        repeat (6) @(negedge sysclk);
        n_cmp++;
        if (rx_q.size() != 0 || mi !== 8'h00 || bus.oRx !== 8'h5A) begin
            n_bad++;
            $display("FAIL cs_high_sck: pulses=%0d miso=%h rx=%h, want 0 00 5a", rx_q.size(), mi, bus.oRx);
        end
    endtask

    task automatic test_cs_sck_same();
        logic [7:0] mi;
        rx_q.delete();
        bus.tx = 8'h96; bus.txReady = 1'b1;
        @(negedge sysclk);
        bus.iSPIMOSI = 1'b1;
        bus.iSPICS   = 1'b0;
        bus.iSPIClk  = 1'b1;
        repeat (4) @(negedge sysclk);
        bus.iSPIClk = 1'b0;
        repeat (4) @(negedge sysclk);
        spi_bits(8'h6E, 8, 1'b0, 8'h00, 1'b0, mi);
        cs_high();
        n_cmp++;
        if (rx_q.size() != 1 || bus.oRx !== 8'h6E || mi !== 8'h96) begin
            n_bad++;
            $display("FAIL cs_sck_same: pulses=%0d rx=%h miso=%h, want 1 6e 96", rx_q.size(), bus.oRx, mi);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] mi;
        bus.tx = 8'hFF; bus.txReady = 1'b1;
        cs_low();
        spi_bits(8'hC3, 4, 1'b0, 8'h00, 1'b0, mi);
        rx_q.delete();
        @(negedge sysclk);
        iRstN = 1'b0;
        #1;
        n_cmp++;
        if (bus.oRx !== 8'h00 || bus.oRxReady !== 1'b0 || bus.oSPIMISO !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid: rx=%h rdy=%b miso=%b, want 00/0/0", bus.oRx, bus.oRxReady, bus.oSPIMISO);
        end
        repeat (3) @(negedge sysclk);
        bus.iSPICS = 1'b1;
        iRstN = 1'b1;
        repeat (6) @(negedge sysclk);
        bus.txReady = 1'b0;
        cs_low();
        spi_bits(8'hC3, 8, 1'b0, 8'h00, 1'b0, mi);
        cs_high();
        n_cmp++;
        if (rx_q.size() != 1 || bus.oRx !== 8'hC3) begin
            n_bad++;
            $display("FAIL reset_recover: pulses=%0d rx=%h, want 1 c3", rx_q.size(), bus.oRx);
        end
    endtask

    task automatic test_echo();
        logic [7:0] m0, m1;
        bit seen;
        seen = 1'b0;
        bus.txReady = 1'b0;
        cs_low();
        fork
            begin
                spi_bits(8'h10, 8, 1'b0, 8'h00, 1'b0, m0);
                spi_bits(8'h00, 8, 1'b0, 8'h00, 1'b0, m1);
            end
            begin
                for (int k = 0; k < 200 && !seen; k++) begin
                    @(negedge sysclk);
                    if (bus.oRxReady === 1'b1) begin
                        bus.tx = bus.oRx + 8'h01;
                        bus.txReady = 1'b1;
                        seen = 1'b1;
                    end
                end
            end
        join
        cs_high();
        n_cmp++;
        if (!seen || m0 !== 8'h00 || m1 !== 8'h11) begin
            n_bad++;
            $display("FAIL echo: seen=%b first=%h second=%h, want 1 00 11", seen, m0, m1);
        end
    endtask

    task automatic test_random();
        logic [7:0] mi, mo, ntx, nxt;
        logic [7:0] exp_rx[$];
        bit nrdy;
        int nb;
        rx_q.delete();
        for (int f = 0; f < 6; f++) begin
            nb = $urandom_range(1, 3);
            bus.tx = 8'($urandom);
            bus.txReady = 1'($urandom);
            nxt = bus.txReady ? bus.tx : 8'h00;
            cs_low();
            for (int b = 0; b < nb; b++) begin
                mo   = 8'($urandom);
                ntx  = 8'($urandom);
                nrdy = 1'($urandom);
                bus.probe = 16'($urandom);
                spi_bits(mo, 8, 1'b1, ntx, nrdy, mi);
                exp_rx.push_back(mo);
                n_cmp++;
                if (mi !== nxt) begin
                    n_bad++;
                    $display("FAIL rand_miso f%0d b%0d: got %h want %h", f, b, mi, nxt);
                end
                nxt = nrdy ? ntx : 8'h00;
            end
            cs_high();
        end
        n_cmp++;
        if (rx_q.size() != exp_rx.size()) begin
            n_bad++;
            $display("FAIL rand_count: pulses=%0d want %0d", rx_q.size(), exp_rx.size());
        end else begin
            foreach (exp_rx[i]) begin
                n_cmp++;
                if (rx_q[i] !== exp_rx[i]) begin
                    n_bad++;
                    $display("FAIL rand_rx %0d: got %h want %h", i, rx_q[i], exp_rx[i]);
                end
            end
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; pulse_cyc = 0; rise_cyc = 0;
        long_pulses = 0; prev_ready = 1'b0;
        iRstN = 1'b0;
        bus.iSPIClk = 1'b0; bus.iSPIMOSI = 1'b0; bus.iSPICS = 1'b1;
        bus.tx = 8'h00; bus.txReady = 1'b0; bus.probe = 16'hBEEF;
        test_reset();
        test_basic();
        test_tx_reply();
        test_back_to_back();
        test_abort();
        test_cs_high_ignore();
        test_cs_sck_same();
        test_reset_mid();
        test_echo();
        test_random();
        n_cmp++;
        if (long_pulses != 0) begin
            n_bad++;
            $display("FAIL pulse_width: %0d pulses longer than one cycle", long_pulses);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_my_spi

// File: doc/my_spi.md
MY_SPI -- requirements
Module: my_spi

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, fixing the frame byte width; only 8 is required to be supported.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth for iSPIClk, iSPIMOSI and iSPICS.
REQ-003 The block SHALL have port sysclk, input, 1 bit: the single system clock, nominally 16 MHz, with all logic on its rising edge.
REQ-004 The block SHALL have port iRstN, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port iSPIClk, input, 1 bit: the SPI clock from the master, asynchronous to sysclk.
REQ-006 The block SHALL have port iSPIMOSI, input, 1 bit: master-out serial data.
REQ-007 The block SHALL have port iSPICS, input, 1 bit: chip select, active-low.
REQ-008 The block SHALL have port oSPIMISO, output, 1 bit: slave-out serial data.
REQ-009 The block SHALL have port oRx, output, 8 bits: the last complete received byte.
REQ-010 The block SHALL have port oRxReady, output, 1 bit: a one-sysclk pulse marking a new oRx.
REQ-011 The block SHALL have port tx, input, 8 bits: the reply byte.
REQ-012 The block SHALL have port txReady, input, 1 bit: when high, tx is valid for the next load.
REQ-013 The block SHALL have port probe, input, 16 bits: a debug observation bus with no functional effect.

Function
REQ-014 SPI mode 0 SHALL apply: CPOL=0, CPHA=0, MSB first, MOSI sampled on rising SCK, MISO changed on falling SCK.
REQ-015 iSPIClk, iSPIMOSI and iSPICS SHALL pass through SYNC_STAGES flops, and SCK and CS edges SHALL be detected in the sysclk domain.
REQ-016 SCK frequency SHALL NOT exceed sysclk/4.
REQ-017 On each synchronized rising SCK with CS low, the sampled MOSI bit SHALL shift into the receive register LSB, and a 3-bit bit counter SHALL increment.
REQ-018 When the 8th bit is sampled, the assembled byte SHALL be written to oRx, and oRxReady SHALL be high for exactly one sysclk on the following cycle.
REQ-019 oRxReady SHALL be asserted within SYNC_STAGES+2 sysclk of the 8th rising SCK at the pins.
REQ-020 oRx SHALL hold its value until the next complete byte arrives.
REQ-021 The bit counter SHALL wrap 7->0, so continuous clocking under one CS assertion yields consecutive bytes.
REQ-022 At a CS falling edge and at each byte boundary, the transmit shift register SHALL load tx if txReady=1; otherwise it SHALL load 8'h00.
REQ-023 oSPIMISO SHALL present the transmit MSB immediately after each load and SHALL shift left on each synchronized falling SCK.
REQ-024 While CS is high, oSPIMISO SHALL drive 0.
REQ-025 A CS rising edge mid-byte SHALL clear the bit counter and discard the partial byte, with no oRxReady pulse and oRx unchanged.
REQ-026 SCK edges while CS is high SHALL be ignored.
REQ-027 If a CS falling edge and an SCK edge are detected in the same sysclk, the CS handling (counter clear, tx load) SHALL take effect first, and that SCK edge SHALL be ignored.
REQ-028 A tx or txReady change mid-byte SHALL NOT affect the byte currently shifting.
REQ-029 The probe bus SHALL NOT influence any output.

Reset
REQ-030 While iRstN=0, the following SHALL be asynchronously cleared: all synchronizers (CS synchronizer to 1, i.e. deselected), the bit counter, the receive register, the transmit shift register, oRx=8'h00, oRxReady=0, oSPIMISO=0.
REQ-031 Reset asserted mid-byte SHALL abort the byte, and after release the block SHALL wait for a new CS falling edge.
REQ-032 Reset release SHALL be synchronized to sysclk.

Structure
REQ-033 A shared package SHALL hold WIDTH, SYNC_STAGES defaults, and the localparam for the idle MISO value (0) and the no-data reply (8'h00).
REQ-034 The block SHALL contain one sub-module, spi_sync_edge, providing synchronizer, rise pulse and fall pulse, instantiated for SCK and for CS (MOSI uses the synchronizer only).

Verification
REQ-035 CS low, master sends 8'hA5 at sysclk/8 -> oRx=8'hA5, and oRxReady is high exactly one cycle within 4 sysclk of the 8th rising SCK.
REQ-036 txReady=1 with tx=8'h3C before CS falls, master clocks 8 bits -> MISO stream 0,0,1,1,1,1,0,0; with txReady=0 -> all zeros.
REQ-037 Two bytes 8'h01 then 8'hFF under one CS -> two oRxReady pulses with oRx 8'h01 then 8'hFF.
REQ-038 CS raised after 5 bits, then full byte 8'h5A -> exactly one pulse, oRx=8'h5A.
REQ-039 iRstN pulsed low mid-byte -> all outputs zero immediately with no pulse; the next full frame 8'hC3 is received correctly.
REQ-040 Echo loop: tx driven as oRx+1 with txReady set on oRxReady; master sends 8'h10 then a dummy byte -> the second frame's MISO reads 8'h11.
